// File: rtl/pipe_pkg.sv
// Shared constants for the RV32I pipeline registers: NOP encoding and control-bundle layout.
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam int CTRL_W         = 8;
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_RESULTSRC_LO = 1;
  localparam int CTRL_RESULTSRC_HI = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_JUMP      = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALUSRC    = 6;

  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pipe_reg.sv
// Enable/clear register: reset > clr > en, all loading CLR_VAL on reset/clr.
// Latency 1 cycle; no backpressure, en low simply holds the current value.
module pipe_reg #(
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) q <= CLR_VAL;
    else if (en)      q <= d;
  end
endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers driven by hazard-unit stall/flush, plus debug counters.
// Latency 1 cycle per stage; backpressure via StallF/StallD hold, FlushD/FlushE insert bubbles.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          CTRL_W   = pipe_pkg::CTRL_W,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  BubbleCnt,
  output logic              HazErr
);
  localparam int IFID_W = 2 * XLEN + 1;
  localparam int IDEX_W = CTRL_W + 15 + 5 * XLEN + 1;

  pipe_reg #(.WIDTH(XLEN), .CLR_VAL(RESET_PC[XLEN-1:0])) u_pc (
    .clk(clk), .reset(reset), .en(!StallF), .clr(1'b0), .d(PCNextF), .q(PCF)
  );

  pipe_reg #(.WIDTH(32), .CLR_VAL(NOP_INSTR)) u_instr_d (
    .clk(clk), .reset(reset), .en(!StallD), .clr(FlushD), .d(InstrF), .q(InstrD)
  );

  pipe_reg #(.WIDTH(IFID_W), .CLR_VAL('0)) u_ifid (
    .clk(clk), .reset(reset), .en(!StallD), .clr(FlushD),
    .d({PCF, PCPlus4F, 1'b1}),
    .q({PCD, PCPlus4D, ValidD})
  );

  // A flushed ID/EX entry is all-zero, so RegWrite and MemWrite are both off.
  pipe_reg #(.WIDTH(IDEX_W), .CLR_VAL('0)) u_idex (
    .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE),
    .d({CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ValidD}),
    .q({CtrlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ValidE})
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
      HazErr    <= 1'b0;
    end else begin
      if (StallF && (StallCnt != '1))  StallCnt  <= StallCnt + 1'b1;
      if (FlushE && (BubbleCnt != '1)) BubbleCnt <= BubbleCnt + 1'b1;
      if (StallF != StallD)            HazErr    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed plus random bench for pipe_stage_regs against a cycle-level reference model.
module tb_pipe_stage_regs;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF, PCPlus4F, PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, ValidE, HazErr;
  logic [7:0]  CtrlD, CtrlE;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic [31:0] RD1D, RD2D, ImmExtD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [CNT_W-1:0] StallCnt, BubbleCnt;

  pipe_stage_regs #(.XLEN(32), .CTRL_W(8), .CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .CtrlD(CtrlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .CtrlE(CtrlE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ValidE(ValidE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt), .HazErr(HazErr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what each architectural register should hold.
  logic [31:0] m_pcf, m_instrd, m_pcd, m_pc4d;
  logic        m_vd;
  logic [31:0] ex_q[$];  // ctrl, rs1, rs2, rd, rd1, rd2, imm, pc, pc4, valid
  int          m_sc, m_bc;
  logic        m_he;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    InstrF = $urandom; PCPlus4F = $urandom; PCNextF = $urandom;
    CtrlD = 8'($urandom); Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
  endtask

  task automatic tick();
    logic [31:0] n_pcf, n_instrd, n_pcd, n_pc4d;
    logic        n_vd, n_he;
    int          n_sc, n_bc;
    logic [31:0] n_ex[$];
    n_pcf = reset ? 32'h0 : (StallF ? m_pcf : PCNextF);
    if (reset || FlushD) begin
      n_instrd = NOP; n_pcd = 0; n_pc4d = 0; n_vd = 0;
    end else if (StallD) begin
      n_instrd = m_instrd; n_pcd = m_pcd; n_pc4d = m_pc4d; n_vd = m_vd;
    end else begin
      n_instrd = InstrF; n_pcd = m_pcf; n_pc4d = PCPlus4F; n_vd = 1'b1;
    end
    if (reset || FlushE) n_ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    else n_ex = '{32'(CtrlD), 32'(Rs1D), 32'(Rs2D), 32'(RdD), RD1D, RD2D, ImmExtD,
                  m_pcd, m_pc4d, 32'(m_vd)};
    n_sc = reset ? 0 : ((StallF && m_sc < SAT) ? m_sc + 1 : m_sc);
    n_bc = reset ? 0 : ((FlushE && m_bc < SAT) ? m_bc + 1 : m_bc);
    n_he = reset ? 1'b0 : (m_he || (StallF != StallD));
    @(posedge clk);
    m_pcf = n_pcf; m_instrd = n_instrd; m_pcd = n_pcd; m_pc4d = n_pc4d; m_vd = n_vd;
    ex_q = n_ex; m_sc = n_sc; m_bc = n_bc; m_he = n_he;
    #1;
    chk("PCF", PCF, m_pcf);
    chk("InstrD", InstrD, m_instrd);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pc4d);
    chk("ValidD", 32'(ValidD), 32'(m_vd));
    chk("CtrlE", 32'(CtrlE), ex_q[0]);
    chk("Rs1E", 32'(Rs1E), ex_q[1]);
    chk("Rs2E", 32'(Rs2E), ex_q[2]);
    chk("RdE", 32'(RdE), ex_q[3]);
    chk("RD1E", RD1E, ex_q[4]);
    chk("RD2E", RD2E, ex_q[5]);
    chk("ImmExtE", ImmExtE, ex_q[6]);
    chk("PCE", PCE, ex_q[7]);
    chk("PCPlus4E", PCPlus4E, ex_q[8]);
    chk("ValidE", 32'(ValidE), ex_q[9]);
    chk("StallCnt", 32'(StallCnt), 32'(m_sc));
    chk("BubbleCnt", 32'(BubbleCnt), 32'(m_bc));
    chk("HazErr", 32'(HazErr), 32'(m_he));
  endtask

  task automatic ctl(input logic sf, input logic sd, input logic fd, input logic fe);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
  endtask

  initial begin
    m_pcf = 0; m_instrd = NOP; m_pcd = 0; m_pc4d = 0; m_vd = 0;
    ex_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; m_sc = 0; m_bc = 0; m_he = 0;

    // Reset with every other input random
    reset = 1'b1;
    ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    rand_data();
    tick();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instr", InstrD, 32'h13);
    chk("rst_valid", 32'({ValidD, ValidE, HazErr}), 32'h0);

    // Free run A, B
    reset = 1'b0; ctl(0, 0, 0, 0);
    rand_data(); PCNextF = 4; InstrF = 32'hA; PCPlus4F = 4;
    tick();
    chk("run_instr_a", InstrD, 32'hA);
    rand_data(); PCNextF = 8; InstrF = 32'hB; PCPlus4F = 8;
    tick();
    chk("run_instr_b", InstrD, 32'hB);
    chk("run_valide", 32'(ValidE), 32'h1);
    chk("run_stallcnt", 32'(StallCnt), 32'h0);

    // Load-use: hold fetch/decode, bubble into EX
    ctl(1, 1, 0, 1); rand_data(); PCNextF = 12; PCPlus4F = 12;
    tick();
    chk("lu_pcf", PCF, 32'h8);
    chk("lu_instr", InstrD, 32'hB);
    chk("lu_valide", 32'({ValidE, CtrlE}), 32'h0);
    chk("lu_cnts", 32'({StallCnt, BubbleCnt}), 32'h11);
    ctl(0, 0, 0, 0); rand_data(); PCNextF = 12; InstrF = 32'hC; PCPlus4F = 12;
    tick();
    chk("lu_b_in_ex", PCE, 32'h4);
    chk("lu_b_valid", 32'(ValidE), 32'h1);

    // Taken branch
    ctl(0, 0, 1, 1); rand_data(); PCNextF = 32'h100;
    tick();
    chk("br_pcf", PCF, 32'h100);
    chk("br_instr", InstrD, NOP);
    chk("br_valid", 32'({ValidD, ValidE}), 32'h0);
    chk("br_bubble", 32'(BubbleCnt), 32'h2);

    // Long stall saturates the 4-bit counter
    ctl(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      rand_data();
      tick();
    end
    chk("sat_stallcnt", 32'(StallCnt), 32'd15);
    ctl(1, 1, 1, 0); rand_data();
    tick();
    chk("stall_flushd", 32'(ValidD), 32'h0);
    chk("stall_hazerr", 32'(HazErr), 32'h0);

    // Protocol error is sticky until reset
    ctl(1, 0, 0, 0); rand_data();
    tick();
    chk("haz_set", 32'(HazErr), 32'h1);
    ctl(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
    end
    chk("haz_sticky", 32'(HazErr), 32'h1);
    ctl(1, 1, 0, 1); reset = 1'b1; rand_data();
    tick();
    chk("mid_rst_haz", 32'(HazErr), 32'h0);
    chk("mid_rst_pcf", PCF, 32'h0);
    reset = 1'b0;

    // Random traffic with stalls biased towards the hazard-unit's legal patterns
    for (int i = 0; i < 400; i++) begin
      automatic logic s = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 59) == 0);
      StallF = s;
      StallD = ($urandom_range(0, 19) == 0) ? ~s : s;
      FlushD = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 4) == 0);
      rand_data();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
